// File: rtl/mix_columns_seq.sv
// Iterative AES-128 MixColumns: one 32-bit column per clock, valid/ready on both sides.
// Define MIX_COLUMNS_INV_EN to add the Inverse port (InvMixColumns).
module mix_columns_seq #(
    parameter int NUM_COLS = 4,
    parameter int COL_W    = 32
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_COLS*COL_W-1:0] InData,
    input  logic                      InValid,
    output logic                      InReady,
    output logic [NUM_COLS*COL_W-1:0] OutData,
    output logic                      OutValid,
    input  logic                      OutReady,
`ifdef MIX_COLUMNS_INV_EN
    input  logic                      Inverse,
`endif
    output logic                      Busy
);

    localparam int DATA_W = NUM_COLS * COL_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   buffer;
    logic [DATA_W-1:0]   nextBuf;
    logic [1:0]          colIdx;
    logic [COL_W-1:0]    curCol;
    logic [COL_W-1:0]    mixedCol;
    logic                opInv;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // Products built from chained doublings so the inverse path shares xtime.
    function automatic logic [31:0] colMix(input logic [31:0] c, input logic inv);
        logic [7:0] a  [4];
        logic [7:0] m2 [4];
        logic [7:0] m3 [4];
        logic [7:0] m4 [4];
        logic [7:0] m8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mB [4];
        logic [7:0] mD [4];
        logic [7:0] mE [4];
        logic [31:0] res;
        logic [1:0] i0;
        logic [1:0] i1;
        logic [1:0] i2;
        logic [1:0] i3;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            a[r]  = c[31-8*r -: 8];
            m2[r] = xtime(a[r]);
            m4[r] = xtime(m2[r]);
            m8[r] = xtime(m4[r]);
            m3[r] = m2[r] ^ a[r];
            m9[r] = m8[r] ^ a[r];
            mB[r] = m8[r] ^ m2[r] ^ a[r];
            mD[r] = m8[r] ^ m4[r] ^ a[r];
            mE[r] = m8[r] ^ m4[r] ^ m2[r];
        end
        for (int r = 0; r < 4; r++) begin
            i0 = 2'(r);
            i1 = 2'(r + 1);
            i2 = 2'(r + 2);
            i3 = 2'(r + 3);
            if (inv)
                res[31-8*r -: 8] = mE[i0] ^ mB[i1] ^ mD[i2] ^ m9[i3];
            else
                res[31-8*r -: 8] = m2[i0] ^ m3[i1] ^ a[i2] ^ a[i3];
        end
        return res;
    endfunction

`ifdef MIX_COLUMNS_INV_EN
    logic invReg;
    assign opInv = invReg;
`else
    assign opInv = 1'b0;
`endif

    always_comb begin
        curCol = '0;
        unique case (colIdx)
            2'd0: curCol = buffer[127:96];
            2'd1: curCol = buffer[95:64];
            2'd2: curCol = buffer[63:32];
            2'd3: curCol = buffer[31:0];
            default: curCol = '0;
        endcase
    end

    assign mixedCol = colMix(curCol, opInv);

    always_comb begin
        nextBuf = buffer;
        unique case (colIdx)
            2'd0: nextBuf[127:96] = mixedCol;
            2'd1: nextBuf[95:64]  = mixedCol;
            2'd2: nextBuf[63:32]  = mixedCol;
            2'd3: nextBuf[31:0]   = mixedCol;
            default: nextBuf = buffer;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            InReady  <= 1'b1;
            OutValid <= 1'b0;
            Busy     <= 1'b0;
            OutData  <= '0;
            colIdx   <= 2'd0;
            buffer   <= '0;
`ifdef MIX_COLUMNS_INV_EN
            invReg   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (InValid) begin
                        buffer  <= InData;
                        colIdx  <= 2'd0;
                        state   <= BUSY;
                        InReady <= 1'b0;
                        Busy    <= 1'b1;
`ifdef MIX_COLUMNS_INV_EN
                        invReg  <= Inverse;
`endif
                    end
                end
                BUSY: begin
                    buffer <= nextBuf;
                    colIdx <= colIdx + 2'd1;
                    if (colIdx == 2'd3) begin
                        state    <= DONE;
                        Busy     <= 1'b0;
                        OutValid <= 1'b1;
                        OutData  <= nextBuf;
                    end
                end
                DONE: begin
                    // No same-cycle accept: InReady rises only once back in IDLE.
                    if (OutReady) begin
                        state    <= IDLE;
                        OutValid <= 1'b0;
                        InReady  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    InReady  <= 1'b1;
                    OutValid <= 1'b0;
                    Busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed-vector bench for mix_columns_seq.
module tb_mix_columns_seq;

    logic         Clk = 1'b0;
    logic         Reset;
    logic [127:0] InData;
    logic         InValid;
    logic         InReady;
    logic [127:0] OutData;
    logic         OutValid;
    logic         OutReady;
    logic         Busy;
`ifdef MIX_COLUMNS_INV_EN
    logic         Inverse;
`endif

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] BP_IN    = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] BP_OUT   = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

    mix_columns_seq dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .InData   (InData),
        .InValid  (InValid),
        .InReady  (InReady),
        .OutData  (OutData),
        .OutValid (OutValid),
        .OutReady (OutReady),
`ifdef MIX_COLUMNS_INV_EN
        .Inverse  (Inverse),
`endif
        .Busy     (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        checks++;
        if (InReady !== 1'b1 || OutValid !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy=%b vld=%b busy=%b want 1 0 0",
                     InReady, OutValid, Busy);
        end
        checks++;
        if (OutData !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", OutData);
        end
        Reset = 1'b0;
        tick();
        checks++;
        if (InReady !== 1'b1 || OutValid !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: got rdy=%b vld=%b want 1 0", InReady, OutValid);
        end
    endtask

    task automatic test_fips();
        InData   = FIPS_IN;
        InValid  = 1'b1;
        OutReady = 1'b1;
        tick();
        InValid = 1'b0;
        checks++;
        if (InReady !== 1'b0 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL fips_accept: got rdy=%b busy=%b want 0 1", InReady, Busy);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (OutValid !== 1'b0 || Busy !== 1'b1) begin
                errors++;
                $display("FAIL fips_busy%0d: got vld=%b busy=%b want 0 1",
                         i, OutValid, Busy);
            end
        end
        tick();
        checks++;
        if (OutValid !== 1'b1 || Busy !== 1'b0 || InReady !== 1'b0) begin
            errors++;
            $display("FAIL fips_latency: got vld=%b busy=%b rdy=%b want 1 0 0",
                     OutValid, Busy, InReady);
        end
        checks++;
        if (OutData !== FIPS_OUT) begin
            errors++;
            $display("FAIL fips_data: got %h want %h", OutData, FIPS_OUT);
        end
        tick();
        checks++;
        if (OutValid !== 1'b0 || InReady !== 1'b1 || OutData !== FIPS_OUT) begin
            errors++;
            $display("FAIL fips_idle: got vld=%b rdy=%b data=%h want 0 1 %h",
                     OutValid, InReady, OutData, FIPS_OUT);
        end
    endtask

    task automatic test_backpressure();
        InData   = BP_IN;
        InValid  = 1'b1;
        OutReady = 1'b0;
        tick();
        InValid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (OutValid !== 1'b1 || InReady !== 1'b0 || OutData !== BP_OUT) begin
                errors++;
                $display("FAIL bp_hold%0d: got vld=%b rdy=%b data=%h want 1 0 %h",
                         i, OutValid, InReady, OutData, BP_OUT);
            end
            tick();
        end
        OutReady = 1'b1;
        tick();
        checks++;
        if (OutValid !== 1'b0 || InReady !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got vld=%b rdy=%b want 0 1", OutValid, InReady);
        end
    endtask

    task automatic test_input_change();
        InData   = FIPS_IN;
        InValid  = 1'b1;
        OutReady = 1'b1;
        tick();
        InData  = '1;
        InValid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (OutValid !== 1'b1 || OutData !== FIPS_OUT) begin
            errors++;
            $display("FAIL in_change: got vld=%b data=%h want 1 %h",
                     OutValid, OutData, FIPS_OUT);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        InData   = BP_IN;
        InValid  = 1'b1;
        OutReady = 1'b1;
        tick();
        InValid = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if (InReady !== 1'b1 || OutValid !== 1'b0 || Busy !== 1'b0 ||
            OutData !== 128'h0) begin
            errors++;
            $display("FAIL mid_reset: got rdy=%b vld=%b busy=%b data=%h want 1 0 0 0",
                     InReady, OutValid, Busy, OutData);
        end
        InData  = FIPS_IN;
        InValid = 1'b1;
        tick();
        InValid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (OutValid !== 1'b1 || OutData !== FIPS_OUT) begin
            errors++;
            $display("FAIL mid_recover: got vld=%b data=%h want 1 %h",
                     OutValid, OutData, FIPS_OUT);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        InData   = FIPS_IN;
        InValid  = 1'b1;
        OutReady = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (OutData !== FIPS_OUT || InReady !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: got data=%h rdy=%b want %h 0",
                     OutData, InReady, FIPS_OUT);
        end
        InData = BP_IN;
        tick();
        checks++;
        if (InReady !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: got rdy=%b busy=%b want 1 0", InReady, Busy);
        end
        tick();
        InValid = 1'b0;
        checks++;
        if (Busy !== 1'b1 || InReady !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b rdy=%b want 1 0", Busy, InReady);
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (OutValid !== 1'b1 || OutData !== BP_OUT) begin
            errors++;
            $display("FAIL b2b_second: got vld=%b data=%h want 1 %h",
                     OutValid, OutData, BP_OUT);
        end
        tick();
    endtask

`ifdef MIX_COLUMNS_INV_EN
    task automatic test_inverse();
        InData   = FIPS_OUT;
        Inverse  = 1'b1;
        InValid  = 1'b1;
        OutReady = 1'b1;
        tick();
        InValid = 1'b0;
        Inverse = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (OutValid !== 1'b1 || OutData !== FIPS_IN) begin
            errors++;
            $display("FAIL inverse: got vld=%b data=%h want 1 %h",
                     OutValid, OutData, FIPS_IN);
        end
        tick();
    endtask
`endif

    initial begin
        Reset    = 1'b0;
        InData   = '0;
        InValid  = 1'b0;
        OutReady = 1'b0;
`ifdef MIX_COLUMNS_INV_EN
        Inverse  = 1'b0;
`endif
        test_reset();
        test_fips();
        test_backpressure();
        test_input_change();
        test_reset_mid();
        test_back_to_back();
`ifdef MIX_COLUMNS_INV_EN
        test_inverse();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
